id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage for an RV32I pipeline.
// Register-file read addresses come straight from the fetched instruction;
// every other output is decoded and registered for the execute stage.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        wen_o,
    output logic        ram_en_o,
    output logic        ram_rw_o,
    output logic        J_o,
    output logic        flag_t_o,
    output logic [3:0]  oprt_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [31:0] ram_indata_o
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;

    localparam logic [31:0] InstNop = 32'h0000_0013;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd     = inst_i[11:7];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign shamt  = {27'b0, inst_i[24:20]};

    // Register-file read ports are driven with zero latency, independent of reset.
    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    logic [31:0] inst_d, inst_q;
    logic [31:0] inst_addr_d, inst_addr_q;
    logic [4:0]  rd_addr_d, rd_addr_q;
    logic        wen_d, wen_q;
    logic        ram_en_d, ram_en_q;
    logic        ram_rw_d, ram_rw_q;
    logic        j_d, j_q;
    logic        flag_t_d, flag_t_q;
    logic [3:0]  oprt_d, oprt_q;
    logic [31:0] op1_d, op1_q;
    logic [31:0] op2_d, op2_q;
    logic [31:0] ram_indata_d, ram_indata_q;

    // ALU operation for the register and immediate arithmetic groups.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // Decode the fetched instruction into next-state values; unknown opcodes become bubbles.
    always_comb begin
        inst_d       = inst_i;
        inst_addr_d  = inst_addr_i;
        rd_addr_d    = rd;
        wen_d        = 1'b0;
        ram_en_d     = 1'b0;
        ram_rw_d     = 1'b0;
        j_d          = 1'b0;
        flag_t_d     = 1'b0;
        oprt_d       = AluAdd;
        op1_d        = 32'b0;
        op2_d        = 32'b0;
        ram_indata_d = 32'b0;

        case (opcode)
            OpcOp: begin
                op1_d  = op1_i;
                op2_d  = op2_i;
                oprt_d = alu_from_funct3(funct3, inst_i[30]);
                wen_d  = 1'b1;
            end
            OpcOpImm: begin
                op1_d = op1_i;
                // Immediate shifts take the 5-bit shamt, not the full I-immediate.
                op2_d  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
                // inst[30] only selects SRAI; ADDI has no subtract form.
                oprt_d = alu_from_funct3(funct3, (funct3 == 3'b101) && inst_i[30]);
                wen_d  = 1'b1;
            end
            OpcLoad: begin
                op1_d    = op1_i;
                op2_d    = imm_i;
                ram_en_d = 1'b1;
                wen_d    = 1'b1;
            end
            OpcStore: begin
                op1_d        = op1_i;
                op2_d        = imm_s;
                ram_en_d     = 1'b1;
                ram_rw_d     = 1'b1;
                ram_indata_d = op2_i;
            end
            OpcLui: begin
                op2_d = imm_u;
                wen_d = 1'b1;
            end
            OpcAuipc: begin
                op1_d = inst_addr_i;
                op2_d = imm_u;
                wen_d = 1'b1;
            end
            OpcJal, OpcJalr: begin
                // Link value pc+4; the jump target is formed downstream.
                j_d   = 1'b1;
                op1_d = inst_addr_i;
                op2_d = 32'd4;
                wen_d = 1'b1;
            end
            OpcBranch: begin
                flag_t_d = 1'b1;
                op1_d    = op1_i;
                op2_d    = op2_i;
                case (funct3[2:1])
                    2'b00:   oprt_d = AluSub;
                    2'b10:   oprt_d = AluSlt;
                    2'b11:   oprt_d = AluSltu;
                    default: oprt_d = AluAdd;
                endcase
            end
            default: ;
        endcase

        // x0 is never written.
        if (rd == 5'd0) begin
            wen_d = 1'b0;
        end
    end

    // Pipeline register; reset presents a NOP to the next stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q       <= InstNop;
            inst_addr_q  <= 32'b0;
            rd_addr_q    <= 5'b0;
            wen_q        <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= 1'b0;
            j_q          <= 1'b0;
            flag_t_q     <= 1'b0;
            oprt_q       <= AluAdd;
            op1_q        <= 32'b0;
            op2_q        <= 32'b0;
            ram_indata_q <= 32'b0;
        end else begin
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            rd_addr_q    <= rd_addr_d;
            wen_q        <= wen_d;
            ram_en_q     <= ram_en_d;
            ram_rw_q     <= ram_rw_d;
            j_q          <= j_d;
            flag_t_q     <= flag_t_d;
            oprt_q       <= oprt_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            ram_indata_q <= ram_indata_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign wen_o        = wen_q;
    assign ram_en_o     = ram_en_q;
    assign ram_rw_o     = ram_rw_q;
    assign J_o          = j_q;
    assign flag_t_o     = flag_t_q;
    assign oprt_o       = oprt_q;
    assign op1_o        = op1_q;
    assign op2_o        = op2_q;
    assign ram_indata_o = ram_indata_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, reset sequences and
// randomized instructions checked against a behavioural decode model.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [4:0]  rd_addr_o;
    logic        wen_o;
    logic        ram_en_o;
    logic        ram_rw_o;
    logic        J_o;
    logic        flag_t_o;
    logic [3:0]  oprt_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] ram_indata_o;

    id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .rd_addr_o    (rd_addr_o),
        .wen_o        (wen_o),
        .ram_en_o     (ram_en_o),
        .ram_rw_o     (ram_rw_o),
        .J_o          (J_o),
        .flag_t_o     (flag_t_o),
        .oprt_o       (oprt_o),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .ram_indata_o (ram_indata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        wen;
        logic        ram_en;
        logic        ram_rw;
        logic        j;
        logic        flag_t;
        logic [3:0]  oprt;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] indata;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] addr,
                                input logic [4:0] rd, input logic wen, input logic ram_en,
                                input logic ram_rw, input logic j, input logic flag_t,
                                input logic [3:0] oprt, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [31:0] indata);
        exp_t e;
        e.inst = inst; e.addr = addr; e.rd = rd; e.wen = wen; e.ram_en = ram_en;
        e.ram_rw = ram_rw; e.j = j; e.flag_t = flag_t; e.oprt = oprt;
        e.op1 = op1; e.op2 = op2; e.indata = indata;
        return e;
    endfunction

    // funct3 -> base ALU code as a nibble table; 'alt' picks SUB/SRA.
    function automatic logic [3:0] model_alu(input logic [2:0] f3, input logic alt);
        logic [31:0] tbl;
        logic [3:0]  base;
        tbl  = 32'h9865_4320;
        base = tbl[f3*4 +: 4];
        return base + {3'b0, alt};
    endfunction

    // Reference decode, built from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        int signed imm12;
        f3 = inst[14:12];
        e  = mk(inst, pc, inst[11:7], 0, 0, 0, 0, 0, 0, 0, 0, 0);
        imm12 = $signed(inst[31:20]);
        case (inst[6:0])
            7'h33: begin
                e.op1 = a; e.op2 = b; e.wen = 1;
                e.oprt = model_alu(f3, inst[30] && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                e.op1 = a; e.wen = 1;
                e.op2 = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : 32'(imm12);
                e.oprt = model_alu(f3, inst[30] && f3 == 5);
            end
            7'h03: begin
                e.op1 = a; e.op2 = 32'(imm12); e.ram_en = 1; e.wen = 1;
            end
            7'h23: begin
                e.op1 = a;
                e.op2 = 32'($signed({inst[31:25], inst[11:7]}));
                e.ram_en = 1; e.ram_rw = 1; e.indata = b;
            end
            7'h37: begin
                e.op2 = inst & 32'hFFFF_F000; e.wen = 1;
            end
            7'h17: begin
                e.op1 = pc; e.op2 = inst & 32'hFFFF_F000; e.wen = 1;
            end
            7'h6F, 7'h67: begin
                e.j = 1; e.op1 = pc; e.op2 = 4; e.wen = 1;
            end
            7'h63: begin
                e.flag_t = 1; e.op1 = a; e.op2 = b;
                if (f3 < 2) e.oprt = 1;
                else if (f3 >= 6) e.oprt = 4;
                else if (f3 >= 4) e.oprt = 3;
                else e.oprt = 0;
            end
            default: ;
        endcase
        if (e.rd == 0) e.wen = 0;
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t want);
        exp_t got;
        got = mk(inst_o, inst_addr_o, rd_addr_o, wen_o, ram_en_o, ram_rw_o, J_o, flag_t_o,
                 oprt_o, op1_o, op2_o, ram_indata_o);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got inst=%h pc=%h rd=%0d wen=%b en=%b rw=%b J=%b br=%b op=%0d op1=%h op2=%h wd=%h | want inst=%h pc=%h rd=%0d wen=%b en=%b rw=%b J=%b br=%b op=%0d op1=%h op2=%h wd=%h",
                     name, got.inst, got.addr, got.rd, got.wen, got.ram_en, got.ram_rw, got.j,
                     got.flag_t, got.oprt, got.op1, got.op2, got.indata, want.inst, want.addr,
                     want.rd, want.wen, want.ram_en, want.ram_rw, want.j, want.flag_t, want.oprt,
                     want.op1, want.op2, want.indata);
        end
    endtask

    task automatic check_rs(input string name, input logic [31:0] inst);
        logic [4:0] w1, w2;
        w1 = inst[19:15];
        w2 = inst[24:20];
        n_checks++;
        if (rs1_addr_o !== w1 || rs2_addr_o !== w2) begin
            n_fail++;
            $display("FAIL %s: got rs1=%0d rs2=%0d want rs1=%0d rs2=%0d",
                     name, rs1_addr_o, rs2_addr_o, w1, w2);
        end
    endtask

    // Drive inputs mid-cycle, check read addresses at once, check registered outputs after the edge.
    task automatic apply(input string name, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] a, input logic [31:0] b, input exp_t want);
        inst_i = inst; inst_addr_i = addr; op1_i = a; op2_i = b;
        #1;
        check_rs({name, "_rs"}, inst);
        @(posedge clk);
        #1;
        check_out(name, want);
    endtask

    exp_t reset_exp;
    vec_t vecs[10];
    logic [6:0] legal_opc[9];

    initial begin
        reset_exp = mk(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        legal_opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};

        vecs[0] = '{32'h0004_2081, 32'hFFFB_DF7E, 32'h0005_DFD3, 32'h0004_2800,
                    mk(32'h0004_2081, 32'hFFFB_DF7E, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{32'h0051_0093, 32'h0000_0100, 32'd10, 32'h77,
                    mk(32'h0051_0093, 32'h100, 1, 1, 0, 0, 0, 0, 0, 10, 5, 0)};
        vecs[2] = '{32'h0031_2423, 32'h0000_0104, 32'h1000, 32'hDEAD_BEEF,
                    mk(32'h0031_2423, 32'h104, 8, 0, 1, 1, 0, 0, 0, 32'h1000, 8, 32'hDEAD_BEEF)};
        vecs[3] = '{32'h1234_52B7, 32'h0000_0108, 32'h55, 32'h66,
                    mk(32'h1234_52B7, 32'h108, 5, 1, 0, 0, 0, 0, 0, 0, 32'h1234_5000, 0)};
        vecs[4] = '{32'h4020_81B3, 32'h0000_010C, 32'd7, 32'd3,
                    mk(32'h4020_81B3, 32'h10C, 3, 1, 0, 0, 0, 0, 1, 7, 3, 0)};
        vecs[5] = '{32'h4032_5213, 32'h0000_0110, 32'h8000_0000, 32'h9,
                    mk(32'h4032_5213, 32'h110, 4, 1, 0, 0, 0, 0, 7, 32'h8000_0000, 3, 0)};
        vecs[6] = '{32'h0000_1317, 32'h0000_2000, 32'h1, 32'h2,
                    mk(32'h0000_1317, 32'h2000, 6, 1, 0, 0, 0, 0, 0, 32'h2000, 32'h1000, 0)};
        vecs[7] = '{32'h0020_A063, 32'h0000_0118, 32'h11, 32'h22,
                    mk(32'h0020_A063, 32'h118, 0, 0, 0, 0, 0, 1, 0, 32'h11, 32'h22, 0)};
        vecs[8] = '{32'hFFC0_A003, 32'h0000_011C, 32'h400, 32'h33,
                    mk(32'hFFC0_A003, 32'h11C, 0, 0, 1, 0, 0, 0, 0, 32'h400, 32'hFFFF_FFFC, 0)};
        vecs[9] = '{32'h0000_0000, 32'h0000_0120, 32'h44, 32'h55,
                    mk(32'h0000_0000, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

        rst_n = 1'b1; inst_i = 0; inst_addr_i = 0; op1_i = 0; op2_i = 0;
        #2 rst_n = 1'b0;
        #1 check_out("reset_async", reset_exp);
        @(posedge clk);
        #1 check_out("reset_held", reset_exp);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].inst, vecs[i].addr, vecs[i].a, vecs[i].b,
                  vecs[i].exp);
        end

        // BEQ followed by JAL x0 on consecutive cycles.
        apply("beq", 32'h0020_8463, 32'h200, 32'h5, 32'h5,
              mk(32'h0020_8463, 32'h200, 8, 0, 0, 0, 0, 1, 1, 5, 5, 0));
        apply("jal_x0", 32'h0080_006F, 32'h204, 32'h9, 32'hA,
              mk(32'h0080_006F, 32'h204, 0, 0, 0, 0, 1, 0, 0, 32'h204, 4, 0));

        // Reset pulled between edges, mid-operation.
        apply("pre_reset", 32'h0051_0093, 32'h300, 32'd10, 0,
              mk(32'h0051_0093, 32'h300, 1, 1, 0, 0, 0, 0, 0, 10, 5, 0));
        #2 rst_n = 1'b0;
        #1 check_out("reset_mid", reset_exp);
        check_rs("rs_in_reset", 32'h0051_0093);
        @(posedge clk);
        #1 check_out("reset_mid_held", reset_exp);
        rst_n = 1'b1;
        #1 check_out("reset_release_no_edge", reset_exp);
        @(posedge clk);
        #1 check_out("resume", model(32'h0051_0093, 32'h300, 32'd10, 0));

        // Randomized instructions against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ri, ra, r1, r2;
            ri = $urandom; ra = $urandom; r1 = $urandom; r2 = $urandom;
            if ($urandom_range(0, 7) != 0) ri[6:0] = legal_opc[$urandom_range(0, 8)];
            apply($sformatf("rand%0d", i), ri, ra, r1, r2, model(ri, ra, r1, r2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want completion");
        $fatal(1);
    end

endmodule
